i2s_mic_array_rx: RTL

//  Parametrised I2S master receiver for an array of MEMS microphones. It derives SCK and WS from the system

---
 rtl/i2s_mic_array_rx.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/i2s_mic_array_rx.sv
// rtl/i2s_mic_array_rx.sv - I2S master receiver for a MEMS microphone array
// Derives SCK/WS from clk, deserialises NUM_SD lines and buffers packed samples in a show-ahead FIFO.
module i2s_mic_array_rx #(
   parameter int NUM_SD     = 3,
   parameter int SAMPLE_W   = 24,
   parameter int SLOT_W     = 32,
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int STEREO     = 0
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             enable,
   output logic                             i2s_sck,
   output logic                             i2s_ws,
   input  logic [NUM_SD-1:0]                i2s_sd,
   output logic [NUM_SD*SAMPLE_W-1:0]       out_data,
   output logic                             out_slot,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
   output logic                             overflow,
   input  logic                             clr_overflow
);
   localparam int DW = $clog2(CLK_DIV);
   localparam int BW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LW = $clog2(FIFO_DEPTH+1);
   localparam int EW = NUM_SD*SAMPLE_W + 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV-1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV/2);
   localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_W-1);
   localparam logic [BW-1:0] BIT_PUSH = BW'(SAMPLE_W-1);
   localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
   localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH-1);

   logic [DW-1:0]               div_cnt, div_nxt;
   logic [BW-1:0]               bit_cnt, bit_nxt;
   logic                        slot, slot_nxt;
   logic                        div_wrap, sample_en, push_trig;
   logic [NUM_SD-1:0]           sd_meta, sd_sync;
   logic [SAMPLE_W-1:0]         shreg [NUM_SD];
   logic [NUM_SD*SAMPLE_W-1:0]  word_nxt;
   logic                        push_req;
   logic [EW-1:0]               push_entry;
   logic [EW-1:0]               mem [FIFO_DEPTH];
   logic [AW-1:0]               wr_ptr, rd_ptr;
   logic                        empty, full, do_push, do_pop;

   always_comb begin
      div_wrap = (div_cnt == DIV_LAST);
      div_nxt  = '0;
      bit_nxt  = '0;
      slot_nxt = 1'b0;
      if (enable) begin
         div_nxt  = div_wrap ? '0 : div_cnt + 1'b1;
         bit_nxt  = bit_cnt;
         slot_nxt = slot;
         if (div_wrap) begin
            bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST)
               slot_nxt = ~slot;
         end
      end
      sample_en = enable && div_wrap && (bit_cnt <= BIT_PUSH);
      push_trig = sample_en && (bit_cnt == BIT_PUSH);
      for (int i = 0; i < NUM_SD; i++)
         word_nxt[i*SAMPLE_W +: SAMPLE_W] = (shreg[i] << 1) | SAMPLE_W'(sd_sync[i]);
   end

   // SCK/WS are registered from the next-state counters so they track div_cnt/bit_cnt without glitches
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         slot    <= 1'b0;
         i2s_sck <= 1'b0;
         i2s_ws  <= 1'b0;
      end else begin
         div_cnt <= div_nxt;
         bit_cnt <= bit_nxt;
         slot    <= slot_nxt;
         i2s_sck <= (div_nxt >= DIV_HALF);
         i2s_ws  <= enable && (slot_nxt ^ (bit_nxt == BIT_LAST));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sd_meta    <= '0;
         sd_sync    <= '0;
         push_req   <= 1'b0;
         push_entry <= '0;
         for (int i = 0; i < NUM_SD; i++)
            shreg[i] <= '0;
      end else begin
         sd_meta  <= i2s_sd;
         sd_sync  <= sd_meta;
         push_req <= push_trig && (!slot || (STEREO != 0));
         if (push_trig)
            push_entry <= {word_nxt, slot};
         for (int i = 0; i < NUM_SD; i++) begin
            if (!enable)
               shreg[i] <= '0;
            else if (sample_en)
               shreg[i] <= word_nxt[i*SAMPLE_W +: SAMPLE_W];
         end
      end
   end

   // A pop only makes room when the FIFO actually holds something, so empty push+pop is just a push
   assign empty     = (fifo_level == '0);
   assign full      = (fifo_level == LVL_FULL);
   assign do_pop    = !empty && out_ready;
   assign do_push   = push_req && (!full || do_pop);
   assign out_valid = !empty;
   assign {out_data, out_slot} = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
         if (push_req && full && !do_pop)
            overflow <= 1'b1;
         else if (clr_overflow)
            overflow <= 1'b0;
      end
   end
endmodule
